// File: rtl/switch_box_config_loader_pkg.sv
// Shared types and helpers for the switch box config loader: FSM states,
// header field layout and payload beat count.
package switch_box_config_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSkip,
    StCommit
  } state_e;

  localparam int unsigned CfgDataW    = 32;
  localparam int unsigned CfgIdW      = 8;
  localparam int unsigned HdrBcastBit = CfgDataW - 1;

  function automatic int unsigned calc_nbeats(input int unsigned conf_w,
                                              input int unsigned data_w);
    return (conf_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/switch_box_config_loader_cfg_word_assembler.sv
// Holds the assembled config vector; writes one DATA_W slice per strobe,
// dropping the bits of the final word that fall past CONF_WIDTH.
module switch_box_config_loader_cfg_word_assembler #(
  parameter int unsigned CONF_WIDTH = 1164,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CNT_W-1:0]      idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [CONF_WIDTH-1:0] c
);

  logic [CONF_WIDTH-1:0] c_q, c_d;

  // Per-bit select keeps truncation of the top word implicit.
  always_comb begin
    c_d = c_q;
    if (wr_en) begin
      for (int unsigned b = 0; b < CONF_WIDTH; b++) begin
        if (idx == CNT_W'(b / DATA_W)) begin
          c_d[b] = wdata[b % DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c = c_q;

endmodule

// File: rtl/switch_box_config_loader.sv
// Stream-fed loader for a disjoint switch box: filters frames by tile id,
// assembles the config word and strobes cset once per complete frame.
module switch_box_config_loader
  import switch_box_config_loader_pkg::*;
#(
  parameter int unsigned W          = 194,
  parameter int unsigned CONF_WIDTH = 6 * W,
  parameter int unsigned DATA_W     = CfgDataW,
  parameter int unsigned ID_W       = CfgIdW,
  parameter int unsigned TILE_ID    = 0,
  parameter int unsigned NBEATS     = calc_nbeats(CONF_WIDTH, DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic                  cfg_last,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  cset,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int unsigned CntW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned BcastBit = DATA_W - 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              xfer, hdr_hit, err_set, wr_en;

  assign xfer    = cfg_valid & ready_q;
  assign hdr_hit = (cfg_data[ID_W-1:0] == ID_W'(TILE_ID)) | cfg_data[BcastBit];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (cfg_last) begin
            err_set = 1'b1;
          end else if (hdr_hit) begin
            state_d = StLoad;
            cnt_d   = '0;
          end else begin
            state_d = StSkip;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(NBEATS - 1)) begin
            if (cfg_last) begin
              state_d = StCommit;
            end else begin
              err_set = 1'b1;
              state_d = StSkip;
            end
          end else if (cfg_last) begin
            err_set = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StSkip: begin
        if (xfer && cfg_last) begin
          state_d = StIdle;
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new error outranks a simultaneous clear.
    err_d   = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    ready_d = (state_d != StCommit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  switch_box_config_loader_cfg_word_assembler #(
    .CONF_WIDTH (CONF_WIDTH),
    .DATA_W     (DATA_W),
    .CNT_W      (CntW)
  ) u_assembler (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .idx   (cnt_q),
    .wdata (cfg_data),
    .c     (c)
  );

  assign cfg_ready = ready_q;
  assign cset      = (state_q == StCommit);
  assign err       = err_q;

endmodule
